// File: rtl/saat_pkg.sv
// Shared constants and state types for the UART time-set receiver.
package saat_pkg;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned SAAT_MAX  = 23;
    localparam int unsigned DK_SN_MAX = 59;

    typedef enum logic [2:0] {
        BEKLE,
        H1,
        H0,
        M1,
        M0,
        S1,
        S0,
        SON
    } parser_durum_t;

    typedef enum logic [2:0] {
        RX_BOSTA,
        RX_BASLA,
        RX_VERI,
        RX_DUR,
        RX_YUKSEK_BEKLE
    } rx_durum_t;

    function automatic logic rakam_mi(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_rx_cekirdek.sv
// UART 8N1 receiver: synchroniser, start verification, bit sampling, framing check.
module uart_rx_cekirdek
    import saat_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_gecerli,
    output logic [7:0] byte_veri,
    output logic       cerceve_hata
);

    localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
    localparam int unsigned YARIM   = BIT_CYC / 2;
    localparam int unsigned SAY_W   = $clog2(BIT_CYC + 1);

    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_d;
    rx_durum_t        r_durum;
    logic [SAY_W-1:0] r_sayac;
    logic [2:0]       r_bit;
    logic [7:0]       r_kaydirma;
    logic             r_byte_gecerli;
    logic [7:0]       r_byte_veri;
    logic             r_cerceve_hata;

    rx_durum_t        w_durum_nxt;
    logic [SAY_W-1:0] w_sayac_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_kaydirma_nxt;
    logic             w_byte_gecerli_nxt;
    logic [7:0]       w_byte_veri_nxt;
    logic             w_cerceve_hata_nxt;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_durum        <= RX_BOSTA;
            r_sayac        <= '0;
            r_bit          <= '0;
            r_kaydirma     <= '0;
            r_byte_gecerli <= 1'b0;
            r_byte_veri    <= '0;
            r_cerceve_hata <= 1'b0;
        end else begin
            r_durum        <= w_durum_nxt;
            r_sayac        <= w_sayac_nxt;
            r_bit          <= w_bit_nxt;
            r_kaydirma     <= w_kaydirma_nxt;
            r_byte_gecerli <= w_byte_gecerli_nxt;
            r_byte_veri    <= w_byte_veri_nxt;
            r_cerceve_hata <= w_cerceve_hata_nxt;
        end
    end

    // Next-state logic: sample mid-bit, reject short start glitches, check stop.
    always_comb begin
        w_durum_nxt        = r_durum;
        w_sayac_nxt        = r_sayac;
        w_bit_nxt          = r_bit;
        w_kaydirma_nxt     = r_kaydirma;
        w_byte_gecerli_nxt = 1'b0;
        w_byte_veri_nxt    = r_byte_veri;
        w_cerceve_hata_nxt = 1'b0;

        case (r_durum)
            RX_BOSTA: begin
                if (r_rx_d && !r_rx_s2) begin
                    w_durum_nxt = RX_BASLA;
                    w_sayac_nxt = '0;
                end
            end
            RX_BASLA: begin
                if (r_sayac == SAY_W'(YARIM - 1)) begin
                    w_sayac_nxt = '0;
                    w_bit_nxt   = '0;
                    w_durum_nxt = r_rx_s2 ? RX_BOSTA : RX_VERI;
                end else begin
                    w_sayac_nxt = r_sayac + SAY_W'(1);
                end
            end
            RX_VERI: begin
                if (r_sayac == SAY_W'(BIT_CYC - 1)) begin
                    w_sayac_nxt    = '0;
                    w_kaydirma_nxt = {r_rx_s2, r_kaydirma[7:1]};
                    if (r_bit == 3'd7) begin
                        w_durum_nxt = RX_DUR;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_sayac_nxt = r_sayac + SAY_W'(1);
                end
            end
            RX_DUR: begin
                if (r_sayac == SAY_W'(BIT_CYC - 1)) begin
                    w_sayac_nxt = '0;
                    if (r_rx_s2) begin
                        w_byte_gecerli_nxt = 1'b1;
                        w_byte_veri_nxt    = r_kaydirma;
                        w_durum_nxt        = RX_BOSTA;
                    end else begin
                        w_cerceve_hata_nxt = 1'b1;
                        w_durum_nxt        = RX_YUKSEK_BEKLE;
                    end
                end else begin
                    w_sayac_nxt = r_sayac + SAY_W'(1);
                end
            end
            RX_YUKSEK_BEKLE: begin
                if (r_rx_s2) begin
                    w_durum_nxt = RX_BOSTA;
                end
            end
            default: begin
                w_durum_nxt = RX_BOSTA;
            end
        endcase
    end

    assign byte_gecerli = r_byte_gecerli;
    assign byte_veri    = r_byte_veri;
    assign cerceve_hata = r_cerceve_hata;

endmodule

// File: rtl/uart_saat_ayar_alici.sv
// Time-set command receiver: UART bytes "T HHMMSS <CR|LF>" to a validated load strobe.
module uart_saat_ayar_alici
    import saat_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx,
    output logic       ayar_gecerli,
    output logic [4:0] saat,
    output logic [5:0] dakika,
    output logic [5:0] saniye,
    output logic       hata,
    output logic       mesgul
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic            w_byte_gecerli;
    logic [7:0]      w_byte_veri;
    logic            w_cerceve_hata;
    logic            w_rakam;
    logic [3:0]      w_birler;
    logic [6:0]      w_deger;
    logic            w_bicim_hata;

    parser_durum_t   r_durum;
    logic [3:0]      r_onlar;
    logic [4:0]      r_saat_ara;
    logic [5:0]      r_dk_ara;
    logic [5:0]      r_sn_ara;
    logic            r_aralik_disi;
    logic [TO_W-1:0] r_zaman;
    logic            r_ayar_gecerli;
    logic [4:0]      r_saat;
    logic [5:0]      r_dakika;
    logic [5:0]      r_saniye;
    logic            r_hata;
    logic            r_mesgul;

    parser_durum_t   w_durum_nxt;
    logic [3:0]      w_onlar_nxt;
    logic [4:0]      w_saat_ara_nxt;
    logic [5:0]      w_dk_ara_nxt;
    logic [5:0]      w_sn_ara_nxt;
    logic            w_aralik_disi_nxt;
    logic [TO_W-1:0] w_zaman_nxt;
    logic            w_ayar_nxt;
    logic [4:0]      w_saat_nxt;
    logic [5:0]      w_dakika_nxt;
    logic [5:0]      w_saniye_nxt;
    logic            w_hata_nxt;

    uart_rx_cekirdek #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .CLK          (CLK),
        .reset        (reset),
        .rx           (rx),
        .byte_gecerli (w_byte_gecerli),
        .byte_veri    (w_byte_veri),
        .cerceve_hata (w_cerceve_hata)
    );

    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign w_rakam  = rakam_mi(w_byte_veri);
    assign w_birler = w_byte_veri[3:0];
    assign w_deger  = 7'(r_onlar) * 7'd10 + 7'(w_birler);

    // Parser state, accumulators, timeout counter and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_durum        <= BEKLE;
            r_onlar        <= '0;
            r_saat_ara     <= '0;
            r_dk_ara       <= '0;
            r_sn_ara       <= '0;
            r_aralik_disi  <= 1'b0;
            r_zaman        <= '0;
            r_ayar_gecerli <= 1'b0;
            r_saat         <= '0;
            r_dakika       <= '0;
            r_saniye       <= '0;
            r_hata         <= 1'b0;
            r_mesgul       <= 1'b0;
        end else begin
            r_durum        <= w_durum_nxt;
            r_onlar        <= w_onlar_nxt;
            r_saat_ara     <= w_saat_ara_nxt;
            r_dk_ara       <= w_dk_ara_nxt;
            r_sn_ara       <= w_sn_ara_nxt;
            r_aralik_disi  <= w_aralik_disi_nxt;
            r_zaman        <= w_zaman_nxt;
            r_ayar_gecerli <= w_ayar_nxt;
            r_saat         <= w_saat_nxt;
            r_dakika       <= w_dakika_nxt;
            r_saniye       <= w_saniye_nxt;
            r_hata         <= w_hata_nxt;
            r_mesgul       <= (w_durum_nxt != BEKLE);
        end
    end

    // Frame parser; out-of-range fields are flagged as they arrive so that
    // values wider than the holding register cannot alias into range.
    always_comb begin
        w_durum_nxt       = r_durum;
        w_onlar_nxt       = r_onlar;
        w_saat_ara_nxt    = r_saat_ara;
        w_dk_ara_nxt      = r_dk_ara;
        w_sn_ara_nxt      = r_sn_ara;
        w_aralik_disi_nxt = r_aralik_disi;
        w_zaman_nxt       = r_zaman;
        w_ayar_nxt        = 1'b0;
        w_saat_nxt        = r_saat;
        w_dakika_nxt      = r_dakika;
        w_saniye_nxt      = r_saniye;
        w_hata_nxt        = 1'b0;
        w_bicim_hata      = 1'b0;

        if (w_cerceve_hata) begin
            w_hata_nxt  = 1'b1;
            w_durum_nxt = BEKLE;
            w_zaman_nxt = '0;
        end else if (w_byte_gecerli) begin
            w_zaman_nxt = '0;
            if (w_byte_veri == ASCII_T) begin
                w_durum_nxt       = H1;
                w_aralik_disi_nxt = 1'b0;
            end else begin
                case (r_durum)
                    BEKLE: begin
                        w_durum_nxt = BEKLE;
                    end
                    H1, M1, S1: begin
                        if (w_rakam) begin
                            w_onlar_nxt = w_birler;
                            w_durum_nxt = (r_durum == H1) ? H0 : ((r_durum == M1) ? M0 : S0);
                        end else begin
                            w_bicim_hata = 1'b1;
                        end
                    end
                    H0: begin
                        if (w_rakam) begin
                            w_saat_ara_nxt = 5'(w_deger);
                            if (w_deger > 7'(SAAT_MAX)) w_aralik_disi_nxt = 1'b1;
                            w_durum_nxt = M1;
                        end else begin
                            w_bicim_hata = 1'b1;
                        end
                    end
                    M0: begin
                        if (w_rakam) begin
                            w_dk_ara_nxt = 6'(w_deger);
                            if (w_deger > 7'(DK_SN_MAX)) w_aralik_disi_nxt = 1'b1;
                            w_durum_nxt = S1;
                        end else begin
                            w_bicim_hata = 1'b1;
                        end
                    end
                    S0: begin
                        if (w_rakam) begin
                            w_sn_ara_nxt = 6'(w_deger);
                            if (w_deger > 7'(DK_SN_MAX)) w_aralik_disi_nxt = 1'b1;
                            w_durum_nxt = SON;
                        end else begin
                            w_bicim_hata = 1'b1;
                        end
                    end
                    SON: begin
                        if ((w_byte_veri == ASCII_CR) || (w_byte_veri == ASCII_LF)) begin
                            if (r_aralik_disi) begin
                                w_hata_nxt = 1'b1;
                            end else begin
                                w_ayar_nxt   = 1'b1;
                                w_saat_nxt   = r_saat_ara;
                                w_dakika_nxt = r_dk_ara;
                                w_saniye_nxt = r_sn_ara;
                            end
                            w_durum_nxt = BEKLE;
                        end else begin
                            w_bicim_hata = 1'b1;
                        end
                    end
                    default: begin
                        w_durum_nxt = BEKLE;
                    end
                endcase
            end
            if (w_bicim_hata) begin
                w_hata_nxt  = 1'b1;
                w_durum_nxt = BEKLE;
            end
        end else if (r_durum != BEKLE) begin
            if (r_zaman == TO_W'(TIMEOUT_CYC - 1)) begin
                w_hata_nxt  = 1'b1;
                w_durum_nxt = BEKLE;
                w_zaman_nxt = '0;
            end else begin
                w_zaman_nxt = r_zaman + TO_W'(1);
            end
        end else begin
            w_zaman_nxt = '0;
        end
    end

    assign ayar_gecerli = r_ayar_gecerli;
    assign saat         = r_saat;
    assign dakika       = r_dakika;
    assign saniye       = r_saniye;
    assign hata         = r_hata;
    assign mesgul       = r_mesgul;

endmodule

// File: tb/tb_uart_saat_ayar_alici.sv
// Self-checking bench for uart_saat_ayar_alici with a frame-buffer reference model.
module tb_uart_saat_ayar_alici;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned BAUD        = 100_000;
    localparam int unsigned TIMEOUT_CYC = 500;
    localparam int          BIT         = 10;
    localparam int          GAP         = 6;

    logic       CLK = 1'b0;
    logic       reset;
    logic       rx;
    logic       ayar_gecerli;
    logic [4:0] saat;
    logic [5:0] dakika;
    logic [5:0] saniye;
    logic       hata;
    logic       mesgul;

    always #5 CLK = ~CLK;

    uart_saat_ayar_alici #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .rx           (rx),
        .ayar_gecerli (ayar_gecerli),
        .saat         (saat),
        .dakika       (dakika),
        .saniye       (saniye),
        .hata         (hata),
        .mesgul       (mesgul)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed pulse counters
    int cyc      = 0;
    int cyc_ayar = 0;
    int n_ayar   = 0;
    int n_hata   = 0;
    int n_both   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ayar_gecerli) begin
            n_ayar   <= n_ayar + 1;
            cyc_ayar <= cyc;
        end
        if (hata) n_hata <= n_hata + 1;
        if (ayar_gecerli && hata) n_both <= n_both + 1;
    end

    // Reference model: buffered frame text, decoded only when the terminator arrives
    logic [7:0] m_buf [8];
    int m_len  = 0;
    int m_ayar = 0;
    int m_hata = 0;
    int m_saat = 0;
    int m_dk   = 0;
    int m_sn   = 0;

    task automatic model_byte(input logic [7:0] b);
        int h, m, s;
        if (m_len == 0) begin
            if (b == 8'h54) m_len = 1;
        end else if (b == 8'h54) begin
            m_len = 1;
        end else if (m_len < 7) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                m_buf[m_len] = b;
                m_len++;
            end else begin
                m_hata++;
                m_len = 0;
            end
        end else begin
            if (b == 8'h0D || b == 8'h0A) begin
                h = (int'(m_buf[1]) - 48) * 10 + (int'(m_buf[2]) - 48);
                m = (int'(m_buf[3]) - 48) * 10 + (int'(m_buf[4]) - 48);
                s = (int'(m_buf[5]) - 48) * 10 + (int'(m_buf[6]) - 48);
                if (h <= 23 && m <= 59 && s <= 59) begin
                    m_ayar++;
                    m_saat = h;
                    m_dk   = m;
                    m_sn   = s;
                end else begin
                    m_hata++;
                end
            end else begin
                m_hata++;
            end
            m_len = 0;
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge CLK);
        end
        rx = stop;
        repeat (BIT) @(negedge CLK);
        rx = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, 1'b1);
        model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({ayar_gecerli, saat, dakika, saniye, hata, mesgul} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {ayar_gecerli, saat, dakika, saniye, hata, mesgul});
        end
        reset = 1'b1;
        repeat (5) @(negedge CLK);
        n_checks++;
        if ({ayar_gecerli, hata, mesgul} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: strobes/busy got %b required 000", {ayar_gecerli, hata, mesgul});
        end
    endtask

    task automatic test_basic;
        int c0;
        send_str("T123456");
        n_checks++;
        if (mesgul !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: mesgul got %b required 1", mesgul);
        end
        c0 = cyc;
        send(8'h0A);
        n_checks++;
        if (n_ayar !== 1 || n_hata !== 0 || m_ayar !== 1) begin
            n_fail++;
            $display("FAIL basic_events: ayar=%0d hata=%0d required ayar=1 hata=0", n_ayar, n_hata);
        end
        n_checks++;
        if ({saat, dakika, saniye} !== {5'd12, 6'd34, 6'd56}) begin
            n_fail++;
            $display("FAIL basic_values: got %0d:%0d:%0d required 12:34:56", saat, dakika, saniye);
        end
        n_checks++;
        if ((cyc_ayar - c0) < 96 || (cyc_ayar - c0) > 100) begin
            n_fail++;
            $display("FAIL basic_latency: strobe %0d cycles after LF start, required 96..100", cyc_ayar - c0);
        end
        n_checks++;
        if (mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: mesgul got %b required 0", mesgul);
        end
    endtask

    task automatic test_range;
        send_str("T250000");
        send(8'h0D);
        n_checks++;
        if (n_ayar !== m_ayar || n_hata !== m_hata || n_hata !== 1) begin
            n_fail++;
            $display("FAIL range_events: ayar=%0d hata=%0d required ayar=%0d hata=%0d",
                     n_ayar, n_hata, m_ayar, m_hata);
        end
        n_checks++;
        if ({saat, dakika, saniye} !== {5'd12, 6'd34, 6'd56}) begin
            n_fail++;
            $display("FAIL range_hold: got %0d:%0d:%0d required 12:34:56", saat, dakika, saniye);
        end
    endtask

    task automatic test_restart;
        send_str("T12T235959");
        send(8'h0D);
        n_checks++;
        if (n_ayar !== m_ayar || n_hata !== m_hata) begin
            n_fail++;
            $display("FAIL restart_events: ayar=%0d hata=%0d required ayar=%0d hata=%0d",
                     n_ayar, n_hata, m_ayar, m_hata);
        end
        n_checks++;
        if ({saat, dakika, saniye} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL restart_values: got %0d:%0d:%0d required 23:59:59", saat, dakika, saniye);
        end
        send_str("T12");
        n_checks++;
        if (mesgul !== 1'b1) begin
            n_fail++;
            $display("FAIL badchar_busy: mesgul got %b required 1", mesgul);
        end
        send_str("x");
        n_checks++;
        if (n_hata !== m_hata || mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL badchar: hata=%0d mesgul=%b required hata=%0d mesgul=0", n_hata, mesgul, m_hata);
        end
    endtask

    task automatic test_framing;
        send_str("T1");
        send_raw(8'h33, 1'b0);
        m_hata++;
        m_len = 0;
        n_checks++;
        if (n_hata !== m_hata || mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL framing: hata=%0d mesgul=%b required hata=%0d mesgul=0", n_hata, mesgul, m_hata);
        end
        send_str("T000000\n");
        n_checks++;
        if (n_ayar !== m_ayar || n_hata !== m_hata || {saat, dakika, saniye} !== 17'd0) begin
            n_fail++;
            $display("FAIL framing_recover: ayar=%0d hata=%0d time=%0d:%0d:%0d required ayar=%0d hata=%0d 0:0:0",
                     n_ayar, n_hata, saat, dakika, saniye, m_ayar, m_hata);
        end
    endtask

    task automatic test_timeout;
        send_str("T12");
        repeat (470) @(negedge CLK);
        n_checks++;
        if (n_hata !== m_hata || mesgul !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: hata=%0d mesgul=%b required hata=%0d mesgul=1", n_hata, mesgul, m_hata);
        end
        repeat (31) @(negedge CLK);
        m_hata++;
        m_len = 0;
        n_checks++;
        if (n_hata !== m_hata || mesgul !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: hata=%0d mesgul=%b required hata=%0d mesgul=0", n_hata, mesgul, m_hata);
        end
        send_str("3456\n");
        n_checks++;
        if (n_ayar !== m_ayar || n_hata !== m_hata || {saat, dakika, saniye} !== 17'd0) begin
            n_fail++;
            $display("FAIL timeout_ignore: ayar=%0d hata=%0d time=%0d:%0d:%0d required ayar=%0d hata=%0d 0:0:0",
                     n_ayar, n_hata, saat, dakika, saniye, m_ayar, m_hata);
        end
    endtask

    task automatic test_glitch;
        send_str("T08");
        rx = 1'b0;
        repeat (3) @(negedge CLK);
        rx = 1'b1;
        repeat (120) @(negedge CLK);
        n_checks++;
        if (n_hata !== m_hata || mesgul !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch: hata=%0d mesgul=%b required hata=%0d mesgul=1", n_hata, mesgul, m_hata);
        end
        send_str("1530\n");
        n_checks++;
        if (n_ayar !== m_ayar || {saat, dakika, saniye} !== {5'd8, 6'd15, 6'd30}) begin
            n_fail++;
            $display("FAIL glitch_frame: ayar=%0d time=%0d:%0d:%0d required ayar=%0d 8:15:30",
                     n_ayar, saat, dakika, saniye, m_ayar);
        end
    endtask

    task automatic test_random;
        int h, m, s, kind, pos;
        logic [7:0] fr [8];
        for (int f = 0; f < 20; f++) begin
            kind = $urandom_range(0, 7);
            if (kind < 5) begin
                h = $urandom_range(0, 23);
                m = $urandom_range(0, 59);
                s = $urandom_range(0, 59);
            end else begin
                h = $urandom_range(0, 29);
                m = $urandom_range(0, 69);
                s = $urandom_range(0, 69);
            end
            if (kind == 7) send(8'($urandom_range(0, 255)));
            fr[0] = 8'h54;
            fr[1] = 8'h30 + 8'(h / 10);
            fr[2] = 8'h30 + 8'(h % 10);
            fr[3] = 8'h30 + 8'(m / 10);
            fr[4] = 8'h30 + 8'(m % 10);
            fr[5] = 8'h30 + 8'(s / 10);
            fr[6] = 8'h30 + 8'(s % 10);
            fr[7] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            if (kind == 6) begin
                pos = $urandom_range(1, 7);
                fr[pos] = 8'h3A + 8'($urandom_range(0, 6));
            end
            for (int i = 0; i < 8; i++) send(fr[i]);
            n_checks++;
            if (n_ayar !== m_ayar || n_hata !== m_hata) begin
                n_fail++;
                $display("FAIL random_events[%0d]: ayar=%0d hata=%0d required ayar=%0d hata=%0d",
                         f, n_ayar, n_hata, m_ayar, m_hata);
            end
            n_checks++;
            if ({saat, dakika, saniye} !== {5'(m_saat), 6'(m_dk), 6'(m_sn)}) begin
                n_fail++;
                $display("FAIL random_values[%0d]: got %0d:%0d:%0d required %0d:%0d:%0d",
                         f, saat, dakika, saniye, m_saat, m_dk, m_sn);
            end
            n_checks++;
            if (mesgul !== (m_len > 0)) begin
                n_fail++;
                $display("FAIL random_busy[%0d]: mesgul got %b required %b", f, mesgul, (m_len > 0));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        send_str("T235958\n");
        send_str("T1");
        b = 8'h32;
        rx = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge CLK);
        end
        rx = b[4];
        repeat (5) @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ayar_gecerli, saat, dakika, saniye, hata, mesgul} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %0d:%0d:%0d mesgul=%b required all zero",
                     saat, dakika, saniye, mesgul);
        end
        rx = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        m_len  = 0;
        m_saat = 0;
        m_dk   = 0;
        m_sn   = 0;
        repeat (5) @(negedge CLK);
        send_str("T071533");
        send(8'h0D);
        n_checks++;
        if (n_ayar !== m_ayar || n_hata !== m_hata || {saat, dakika, saniye} !== {5'd7, 6'd15, 6'd33}) begin
            n_fail++;
            $display("FAIL reset_recover: ayar=%0d hata=%0d time=%0d:%0d:%0d required ayar=%0d hata=%0d 7:15:33",
                     n_ayar, n_hata, saat, dakika, saniye, m_ayar, m_hata);
        end
    endtask

    task automatic test_no_overlap;
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL overlap: hata and ayar_gecerli together in %0d cycles, required 0", n_both);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_range;
        test_restart;
        test_framing;
        test_timeout;
        test_glitch;
        test_random;
        test_reset_mid;
        test_no_overlap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_saat_ayar_alici.md
Name: uart_saat_ayar_alici

Overview:
- Upstream stage of the clock-update core: turns serial time-set commands on the board UART line into a validated time-load request.
- Contains a UART 8N1 receiver and a command parser for ASCII frames of the form 'T' H H M M S S terminator.
- Output is a one-cycle load strobe plus BCD-free binary hour/minute/second values, which the clock-update core loads into its counters.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 9600, UART bit rate.
- TIMEOUT_CYC, 10_000_000, maximum idle cycles allowed between bytes of one frame (100 ms at default clock).

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART receive line, asynchronous to CLK, idle high.
- ayar_gecerli  out  1  one-cycle strobe: new time is valid on saat/dakika/saniye.
- saat  out  5  hour, 0..23.
- dakika  out  6  minute, 0..59.
- saniye  out  6  second, 0..59.
- hata  out  1  one-cycle strobe on framing, format, range or timeout error.
- mesgul  out  1  high while a frame is partially received (parser not in BEKLE).

Behaviour:
- Reset (reset=0, async): all outputs 0, receiver to idle, parser to BEKLE, all counters cleared. A reset mid-byte or mid-frame discards that byte or frame.
- Receiver, BIT_CYC = CLK_HZ/BAUD:
  - rx passes through a 2-flop synchroniser, reset value 1.
  - Start is detected on a synchronised 1->0 transition while idle.
  - rx is re-checked at BIT_CYC/2; if it is high there, the start is rejected as a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first, each BIT_CYC after the previous sample.
  - The stop bit is sampled BIT_CYC after data bit 7.
  - Stop=1: byte_gecerli pulses for 1 cycle with the byte.
  - Stop=0: framing-error pulse, no byte is delivered, and the receiver waits for rx high before re-arming.
- Parser FSM states: BEKLE, H1, H0, M1, M0, S1, S0, SON.
  - BEKLE: byte 'T' (0x54) -> H1; any other byte is ignored with no hata.
  - H1..S0: the byte must be ASCII '0'..'9'. It is accumulated as tens*10+units into a 5- or 6-bit register, then the FSM advances to the next state.
  - 'T' in any state other than BEKLE restarts at H1 silently, with partial values discarded.
  - Any other non-digit -> hata, go to BEKLE.
  - SON: CR (0x0D) or LF (0x0A) -> range check (saat<=23, dakika<=59, saniye<=59). Pass -> ayar_gecerli. Fail -> hata. Either way -> BEKLE.
  - SON with any other byte: 'T' restarts at H1 silently; anything else -> hata, BEKLE.
- Latency: ayar_gecerli is asserted the cycle after the terminator's byte_gecerli. saat/dakika/saniye update on that same edge and hold until the next successful frame; errors never alter them.
- Timeout: in any state other than BEKLE, a counter that reaches TIMEOUT_CYC without a new byte -> hata, BEKLE. The counter is cleared on every byte_gecerli.
- Framing error in any parser state -> hata; the parser goes to BEKLE.
- Simultaneous events:
  - At most one byte per BIT_CYC*10, so byte and timeout coincide only at the boundary; the byte wins and the timeout is discarded.
  - hata and ayar_gecerli are never high in the same cycle.

Decomposition:
- Shared package saat_pkg:
  - ASCII constants: 'T', '0', CR, LF.
  - Limits SAAT_MAX=23 and DK_SN_MAX=59.
  - Parser state enum.
- Sub-module uart_rx_cekirdek holds the synchroniser, start verification, bit and sample counters and framing check. Its outputs are byte_gecerli, byte_veri[7:0] and cerceve_hata.
- The parser FSM and timeout counter live in the top block.

Test Plan:
Bench uses CLK_HZ=1_000_000, BAUD=100_000 (10 cycles/bit) and TIMEOUT_CYC=500.
- Send "T123456\n" -> exactly one ayar_gecerli pulse, 1 cycle after the LF byte_gecerli; saat=12, dakika=34, saniye=56; hata never asserted.
- After the first scenario, send "T250000\r" -> one hata pulse, no ayar_gecerli; outputs stay 12/34/56.
- Send "T12T235959\r" -> no hata; one ayar_gecerli with 23/59/59. Separately, "T12x" -> hata on 'x', mesgul falls.
- Send a byte with stop bit forced 0 mid-frame -> hata, parser returns to BEKLE; the following "T000000\n" loads 0/0/0.
- Send "T12", then hold rx high for 501 cycles -> hata at the timeout and mesgul drops. Then send "3456\n" -> nothing, since digits and LF in BEKLE are ignored.
- Apply a 3-cycle low glitch on idle rx -> no byte and no hata. Assert reset during bit 4 of a byte -> all outputs 0 asynchronously; the next full frame decodes correctly.
